// File: rtl/ftdi_fifo_bridge.sv
// ============================================================================
// Module   : ftdi_fifo_bridge
// Brief    : FT245 parallel-FIFO bus master with user-side RX/TX byte FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftdi_fifo_bridge #(
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16,
    parameter int RD_PULSE    = 3,
    parameter int WR_PULSE    = 2,
    parameter int GAP         = 2,
    parameter int TX_PRIORITY = 0
) (
    input  logic                        clock_in,
    input  logic                        reset,
    inout  wire  [7:0]                  ft_data,
    input  logic                        ft_txe_n,
    input  logic                        ft_rxf_n,
    output logic                        ft_rd_n,
    output logic                        ft_wr_n,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [$clog2(TX_DEPTH):0]   tx_level
);

    localparam int c_RX_AW = $clog2(RX_DEPTH);
    localparam int c_TX_AW = $clog2(TX_DEPTH);
    localparam int c_RX_LW = c_RX_AW + 1;
    localparam int c_TX_LW = c_TX_AW + 1;

    localparam int c_MAX_RW  = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int c_MAX_CNT = (c_MAX_RW > GAP) ? c_MAX_RW : GAP;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0] c_RD_LAST  = c_CNT_W'(RD_PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LAST  = c_CNT_W'(WR_PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP - 1);

    localparam logic [c_RX_LW-1:0] c_RX_FULL = c_RX_LW'(RX_DEPTH);
    localparam logic [c_TX_LW-1:0] c_TX_FULL = c_TX_LW'(TX_DEPTH);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_RD_LOW   = 3'd1;
    localparam logic [2:0] c_WR_SETUP = 3'd2;
    localparam logic [2:0] c_WR_LOW   = 3'd3;
    localparam logic [2:0] c_WR_HOLD  = 3'd4;
    localparam logic [2:0] c_RECOVER  = 3'd5;

    // ------------------------------------------------------------------
    // Flag synchronisers (reset to the inactive level)
    // ------------------------------------------------------------------
    logic txe_meta_q, txe_sync_q;
    logic rxf_meta_q, rxf_sync_q;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            txe_meta_q <= 1'b1;
            txe_sync_q <= 1'b1;
            rxf_meta_q <= 1'b1;
            rxf_sync_q <= 1'b1;
        end else begin
            txe_meta_q <= ft_txe_n;
            txe_sync_q <= txe_meta_q;
            rxf_meta_q <= ft_rxf_n;
            rxf_sync_q <= rxf_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO: user pushes, bus pops
    // ------------------------------------------------------------------
    logic [7:0]         tx_mem_q [TX_DEPTH];
    logic [c_TX_AW-1:0] tx_wptr_q;
    logic [c_TX_AW-1:0] tx_rptr_q;
    logic [c_TX_LW-1:0] tx_level_q;
    logic               w_tx_push;
    logic               w_tx_pop;

    assign tx_ready  = (tx_level_q != c_TX_FULL);
    assign w_tx_push = tx_valid && tx_ready;
    assign tx_level  = tx_level_q;

    always_ff @(posedge clock_in) begin
        if (w_tx_push) begin
            tx_mem_q[tx_wptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
        end else begin
            if (w_tx_push) begin
                tx_wptr_q <= tx_wptr_q + c_TX_AW'(1);
            end
            if (w_tx_pop) begin
                tx_rptr_q <= tx_rptr_q + c_TX_AW'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   tx_level_q <= tx_level_q + c_TX_LW'(1);
                2'b01:   tx_level_q <= tx_level_q - c_TX_LW'(1);
                default: tx_level_q <= tx_level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO: bus pushes, user pops
    // ------------------------------------------------------------------
    logic [7:0]         rx_mem_q [RX_DEPTH];
    logic [c_RX_AW-1:0] rx_wptr_q;
    logic [c_RX_AW-1:0] rx_rptr_q;
    logic [c_RX_LW-1:0] rx_level_q;
    logic               w_rx_push;
    logic               w_rx_pop;

    assign rx_valid = (rx_level_q != '0);
    assign w_rx_pop = rx_valid && rx_ready;
    assign rx_data  = rx_mem_q[rx_rptr_q];
    assign rx_level = rx_level_q;

    // Byte is captured straight off the bus on the edge ending the last low cycle.
    always_ff @(posedge clock_in) begin
        if (w_rx_push) begin
            rx_mem_q[rx_wptr_q] <= ft_data;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
        end else begin
            if (w_rx_push) begin
                rx_wptr_q <= rx_wptr_q + c_RX_AW'(1);
            end
            if (w_rx_pop) begin
                rx_rptr_q <= rx_rptr_q + c_RX_AW'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   rx_level_q <= rx_level_q + c_RX_LW'(1);
                2'b01:   rx_level_q <= rx_level_q - c_RX_LW'(1);
                default: rx_level_q <= rx_level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------
    logic [2:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               rr_tx_q, rr_tx_d;
    logic [7:0]         dout_q, dout_d;
    logic               rd_n_q, wr_n_q, oe_q;
    logic               w_rx_elig;
    logic               w_tx_elig;

    assign w_rx_elig = !rxf_sync_q && (rx_level_q != c_RX_FULL);
    assign w_tx_elig = !txe_sync_q && (tx_level_q != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_tx_d   = rr_tx_q;
        dout_d    = dout_q;
        w_rx_push = 1'b0;
        w_tx_pop  = 1'b0;
        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                // rr_tx_q set means RX was served last, so TX gets the tie.
                if (w_tx_elig && (!w_rx_elig || (TX_PRIORITY != 0) || rr_tx_q)) begin
                    state_d = c_WR_SETUP;
                    dout_d  = tx_mem_q[tx_rptr_q];
                    rr_tx_d = 1'b0;
                end else if (w_rx_elig) begin
                    state_d = c_RD_LOW;
                    rr_tx_d = 1'b1;
                end
            end
            c_RD_LOW: begin
                if (cnt_q == c_RD_LAST) begin
                    w_rx_push = 1'b1;
                    state_d   = c_RECOVER;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_WR_SETUP: begin
                state_d = c_WR_LOW;
                cnt_d   = '0;
            end
            c_WR_LOW: begin
                if (cnt_q == c_WR_LAST) begin
                    w_tx_pop = 1'b1;
                    state_d  = c_WR_HOLD;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_WR_HOLD: begin
                state_d = c_RECOVER;
                cnt_d   = '0;
            end
            c_RECOVER: begin
                if (cnt_q == c_GAP_LAST) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes and output enable are decoded from next state so they are glitch-free flops.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            rr_tx_q <= 1'b0;
            dout_q  <= '0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_tx_q <= rr_tx_d;
            dout_q  <= dout_d;
            rd_n_q  <= (state_d != c_RD_LOW);
            wr_n_q  <= (state_d != c_WR_LOW);
            oe_q    <= (state_d == c_WR_SETUP) || (state_d == c_WR_LOW) ||
                       (state_d == c_WR_HOLD);
        end
    end

    assign ft_rd_n = rd_n_q;
    assign ft_wr_n = wr_n_q;
    assign ft_data = oe_q ? dout_q : 8'hzz;

endmodule

`default_nettype wire

// File: tb/tb_ftdi_fifo_bridge.sv
// ============================================================================
// Module   : tb_ftdi_fifo_bridge
// Brief    : Directed self-checking bench for ftdi_fifo_bridge (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ftdi_fifo_bridge;

    logic       clock_in = 1'b0;
    logic       reset;
    wire  [7:0] ft_data;
    logic       ft_txe_n;
    logic       ft_rxf_n;
    logic       ft_rd_n;
    logic       ft_wr_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] rx_level;
    logic [4:0] tx_level;

    logic       probe_en;
    logic [7:0] pc_base;

    int n_vec = 0;
    int n_err = 0;

    int         rd_pulses   = 0;
    int         wr_pulses   = 0;
    int         rd_cnt      = 0;
    int         wr_cnt      = 0;
    int         last_rd_len = 0;
    int         last_wr_len = 0;
    int         wr_bad      = 0;
    int         both_low    = 0;
    logic       prev_wr_n   = 1'b1;
    logic [7:0] prev_data   = 8'h00;
    logic [7:0] wr_first    = 8'h00;
    bit         order_q[$];
    logic [7:0] wr_log[$];

    always #5 clock_in = ~clock_in;

    ftdi_fifo_bridge dut (
        .clock_in (clock_in),
        .reset    (reset),
        .ft_data  (ft_data),
        .ft_txe_n (ft_txe_n),
        .ft_rxf_n (ft_rxf_n),
        .ft_rd_n  (ft_rd_n),
        .ft_wr_n  (ft_wr_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_level (rx_level),
        .tx_level (tx_level)
    );

    // PC-side FT245 model: k-th byte read is pc_base + k; probe drives a marker.
    wire [7:0] w_pc_byte = pc_base + rd_pulses[7:0];
    assign ft_data = probe_en ? 8'h3C : ((ft_rd_n == 1'b0) ? w_pc_byte : 8'hzz);

    always @(negedge clock_in) begin
        if (ft_rd_n == 1'b0 && ft_wr_n == 1'b0) both_low++;
        if (ft_rd_n == 1'b0) begin
            rd_cnt++;
        end else if (rd_cnt != 0) begin
            last_rd_len = rd_cnt;
            rd_cnt      = 0;
            rd_pulses++;
            order_q.push_back(1'b0);
        end
        if (ft_wr_n == 1'b0) begin
            if (wr_cnt == 0) begin
                wr_first = ft_data;
                if (prev_wr_n !== 1'b1 || prev_data !== ft_data) wr_bad++;
            end else if (ft_data !== wr_first) begin
                wr_bad++;
            end
            wr_cnt++;
        end else if (wr_cnt != 0) begin
            if (ft_data !== wr_first) wr_bad++;
            last_wr_len = wr_cnt;
            wr_cnt      = 0;
            wr_pulses++;
            order_q.push_back(1'b1);
            wr_log.push_back(wr_first);
        end
        prev_wr_n = ft_wr_n;
        prev_data = ft_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic wait_rd_low(input string tag, input int budget);
        int k = 0;
        while (ft_rd_n !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, ft_rd_n}, 32'd0);
    endtask

    task automatic wait_wr_low(input string tag, input int budget);
        int k = 0;
        while (ft_wr_n !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, ft_wr_n}, 32'd0);
    endtask

    task automatic wait_rd_count(input string tag, input int target, input int budget);
        int k = 0;
        while (rd_pulses < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, rd_pulses, target);
    endtask

    task automatic wait_wr_count(input string tag, input int target, input int budget);
        int k = 0;
        while (wr_pulses < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, wr_pulses, target);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        int r0, w0, b0, l0, o0;
        reset    = 1'b1;
        ft_txe_n = 1'b1;
        ft_rxf_n = 1'b1;
        rx_ready = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        probe_en = 1'b0;
        pc_base  = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check("rst_rd_n", {31'd0, ft_rd_n}, 32'd1);
        check("rst_wr_n", {31'd0, ft_wr_n}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_level", {27'd0, rx_level}, 32'd0);
        check("rst_tx_level", {27'd0, tx_level}, 32'd0);
        probe_en = 1'b1;
        #1;
        check("rst_bus_free", {24'd0, ft_data}, 32'h3C);
        probe_en = 1'b0;

        // Single read of 0x5A
        r0       = rd_pulses;
        pc_base  = 8'h5A - 8'(rd_pulses);
        ft_rxf_n = 1'b0;
        wait_rd_low("rd_start", 20);
        ft_rxf_n = 1'b1;
        wait_rd_count("rd_done", r0 + 1, 20);
        tick(4);
        check("rd_len", last_rd_len, 32'd3);
        check("rd_count", rd_pulses - r0, 32'd1);
        check("rd_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("rd_rx_data", {24'd0, rx_data}, 32'h5A);
        check("rd_rx_level", {27'd0, rx_level}, 32'd1);
        pop_rx();
        check("rd_pop_level", {27'd0, rx_level}, 32'd0);
        check("rd_pop_valid", {31'd0, rx_valid}, 32'd0);

        // Single write of 0xA5
        w0 = wr_pulses;
        b0 = wr_bad;
        l0 = wr_log.size();
        push_tx(8'hA5);
        check("wr_tx_level1", {27'd0, tx_level}, 32'd1);
        ft_txe_n = 1'b0;
        wait_wr_low("wr_start", 20);
        ft_txe_n = 1'b1;
        wait_wr_count("wr_done", w0 + 1, 20);
        tick(2);
        check("wr_len", last_wr_len, 32'd2);
        check("wr_byte", {24'd0, wr_log[l0]}, 32'hA5);
        check("wr_stable", wr_bad - b0, 32'd0);
        check("wr_tx_level0", {27'd0, tx_level}, 32'd0);
        check("wr_tx_ready", {31'd0, tx_ready}, 32'd1);

        // Contention with round-robin: R W R W R W R W
        for (int i = 0; i < 4; i++) push_tx(8'h40 + 8'(i));
        check("ct_tx_level", {27'd0, tx_level}, 32'd4);
        rx_ready = 1'b1;
        o0       = order_q.size();
        w0       = wr_pulses;
        l0       = wr_log.size();
        pc_base  = 8'h00;
        ft_txe_n = 1'b0;
        ft_rxf_n = 1'b0;
        wait_wr_count("ct_writes", w0 + 4, 200);
        ft_rxf_n = 1'b1;
        ft_txe_n = 1'b1;
        tick(10);
        rx_ready = 1'b0;
        check("ct_events", {31'd0, order_q.size() >= o0 + 8}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (order_q.size() > o0 + i)
                check($sformatf("ct_order%0d", i), {31'd0, order_q[o0 + i]}, 32'(i % 2));
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("ct_byte%0d", i), {24'd0, wr_log[l0 + i]}, 32'h40 + 32'(i));

        // RX full backpressure
        do_reset();
        r0       = rd_pulses;
        pc_base  = 8'h10 - 8'(rd_pulses);
        ft_rxf_n = 1'b0;
        wait_rd_count("full_reads", r0 + 16, 300);
        tick(30);
        check("full_no_more", rd_pulses - r0, 32'd16);
        check("full_level", {27'd0, rx_level}, 32'd16);
        check("full_rd_n", {31'd0, ft_rd_n}, 32'd1);
        check("full_head", {24'd0, rx_data}, 32'h10);
        pop_rx();
        wait_rd_count("full_resume", r0 + 17, 30);
        ft_rxf_n = 1'b1;
        tick(6);
        check("full_level2", {27'd0, rx_level}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_data%0d", i), {24'd0, rx_data}, 32'h11 + 32'(i));
            pop_rx();
        end
        check("full_drained", {27'd0, rx_level}, 32'd0);

        // TX full, then drain in order
        w0 = wr_pulses;
        b0 = wr_bad;
        l0 = wr_log.size();
        for (int i = 0; i < 16; i++) push_tx(8'h80 + 8'(i));
        push_tx(8'hEE);
        check("txf_level", {27'd0, tx_level}, 32'd16);
        check("txf_ready", {31'd0, tx_ready}, 32'd0);
        tick(20);
        check("txf_no_write", wr_pulses - w0, 32'd0);
        ft_txe_n = 1'b0;
        wait_wr_count("txf_writes", w0 + 16, 400);
        ft_txe_n = 1'b1;
        tick(4);
        check("txf_count", wr_pulses - w0, 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("txf_byte%0d", i), {24'd0, wr_log[l0 + i]}, 32'h80 + 32'(i));
        check("txf_level0", {27'd0, tx_level}, 32'd0);
        check("txf_stable", wr_bad - b0, 32'd0);

        // Reset during WR_LOW
        push_tx(8'h77);
        ft_txe_n = 1'b0;
        wait_wr_low("rw_start", 20);
        reset = 1'b1;
        tick(1);
        check("rw_wr_n", {31'd0, ft_wr_n}, 32'd1);
        check("rw_tx_level", {27'd0, tx_level}, 32'd0);
        check("rw_tx_ready", {31'd0, tx_ready}, 32'd1);
        probe_en = 1'b1;
        #1;
        check("rw_bus_free", {24'd0, ft_data}, 32'h3C);
        probe_en = 1'b0;
        reset = 1'b0;
        tick(2);
        w0 = wr_pulses;
        tick(15);
        check("rw_idle", wr_pulses - w0, 32'd0);
        check("rw_rd_n", {31'd0, ft_rd_n}, 32'd1);
        l0 = wr_log.size();
        push_tx(8'h99);
        wait_wr_count("rw_after", w0 + 1, 30);
        tick(2);
        check("rw_byte", {24'd0, wr_log[l0]}, 32'h99);
        ft_txe_n = 1'b1;

        check("never_both_low", both_low, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ftdi_fifo_bridge.md
FTDI_FIFO_BRIDGE -- requirements
Module: ftdi_fifo_bridge

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 16, meaning RX FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries (power of two, 2..256).
REQ-003 SHALL have parameter RD_PULSE, default 3, meaning cycles rd_n is held low per read (>=2).
REQ-004 SHALL have parameter WR_PULSE, default 2, meaning cycles wr_n is held low per write (>=1).
REQ-005 SHALL have parameter GAP, default 2, meaning idle cycles after each bus transfer (>=1).
REQ-006 SHALL have parameter TX_PRIORITY, default 0, meaning 1 = TX wins contention, 0 = round-robin.
REQ-007 SHALL have ports:
 clock_in  in  1  system clock, all logic on posedge
 reset  in  1  synchronous, active-high
 ft_data  inout  8  FT245 data bus
 ft_txe_n  in  1  0 = FT245 accepts a byte
 ft_rxf_n  in  1  0 = FT245 holds a byte from PC
 ft_rd_n  out  1  read strobe, active low
 ft_wr_n  out  1  write strobe, active low
 rx_data  out  8  byte to user, valid with rx_valid
 rx_valid  out  1  rx_data available
 rx_ready  in  1  user accepts rx_data
 tx_data  in  8  byte from user
 tx_valid  in  1  tx_data offered
 tx_ready  out  1  TX FIFO can accept
 rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
 tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy

Function
REQ-008 SHALL pass ft_txe_n and ft_rxf_n through 2-flop synchronisers; all decisions use synchronised values.
REQ-009 SHALL transfer a user byte when tx_valid and tx_ready are high on the same edge; tx_ready = TX FIFO not full.
REQ-010 SHALL present RX FIFO head on rx_data with rx_valid = RX FIFO not empty; pop when rx_valid and rx_ready are both high.
REQ-011 SHALL use bus FSM states IDLE, RD_LOW, WR_SETUP, WR_LOW, WR_HOLD, RECOVER.
REQ-012 SHALL treat RX as eligible when synced rxf_n = 0 and RX FIFO not full; TX as eligible when synced txe_n = 0 and TX FIFO not empty.
REQ-013 SHALL, in IDLE with both eligible, pick TX if TX_PRIORITY = 1, else the direction not served last.
REQ-014 SHALL, in RD_LOW, drive ft_rd_n low for RD_PULSE cycles, register ft_data on the last low cycle, then drive ft_rd_n high, push the byte, enter RECOVER.
REQ-015 SHALL, in WR_SETUP, drive the TX FIFO head onto ft_data for 1 cycle with ft_wr_n high.
REQ-016 SHALL, in WR_LOW, hold ft_wr_n low for WR_PULSE cycles with data stable, then raise it, pop TX FIFO, enter WR_HOLD.
REQ-017 SHALL, in WR_HOLD, keep data driven 1 cycle with ft_wr_n high, then tristate and enter RECOVER.
REQ-018 SHALL stay in RECOVER GAP cycles, then return to IDLE.
REQ-019 SHALL drive ft_data only in WR_SETUP, WR_LOW and WR_HOLD; never with ft_rd_n low.
REQ-020 SHALL never assert ft_rd_n and ft_wr_n low together.
REQ-021 SHALL not start a read when RX FIFO is full; ft_rxf_n stays low, backpressuring the PC.
REQ-022 SHALL allow a user push and a bus pop (TX), or a bus push and a user pop (RX), on one edge; level unchanged.
REQ-023 SHALL wrap FIFO pointers modulo depth; levels are exact 0..DEPTH.
REQ-024 SHALL register ft_rd_n and ft_wr_n outputs (no glitches).

Reset
REQ-025 SHALL on reset: FSM to IDLE, ft_rd_n = 1, ft_wr_n = 1, ft_data tristated, both FIFOs emptied, rx_valid = 0, tx_ready = 1, levels = 0, round-robin pointer to RX.
REQ-026 SHALL on reset mid-transfer release strobes next cycle and discard the in-flight byte.

Verification
REQ-027 Read: ft_rxf_n=0, bus 0x5A, RD_PULSE=3 -> rd_n low 3 cycles, rx_valid with rx_data=0x5A, rx_level=1.
REQ-028 Write: push 0xA5, ft_txe_n=0 -> 1 setup cycle, wr_n low 2 cycles, data 0xA5 stable throughout, tx_level 1->0.
REQ-029 Contention, TX_PRIORITY=0, both eligible continuously -> strict RX/WR/RX/WR alternation starting with RX.
REQ-030 RX full: 16 reads, rx_ready=0 -> rx_level=16, no further rd_n pulses until one pop.
REQ-031 TX full: 16 pushes, ft_txe_n=1 -> tx_ready=0, no wr_n pulse; release txe_n -> 16 writes in order.
REQ-032 Reset asserted during WR_LOW -> next cycle wr_n=1, bus Z, tx_level=0, FSM IDLE.
